oam_dma_arbiter: RTL



---
 rtl/nese_bus_pkg.sv | 17 +
 rtl/oam_dma_arbiter.sv | 94 +++++++++
 2 files changed

// File: rtl/nese_bus_pkg.sv
// Shared types and defaults for the 2A03 bus arbitration logic.
// Holds the OAM DMA state encoding and the default trigger/destination addresses.
package nese_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    localparam logic [15:0] DEF_TRIG_ADDR = 16'h4014;
    localparam logic [15:0] DEF_OAM_ADDR  = 16'h2004;
    localparam logic        RW_READ       = 1'b1;

endpackage

// File: rtl/oam_dma_arbiter.sv
// Sprite DMA arbiter: halts the CPU core via RDY and copies one 256-byte page
// to the PPU OAM data port, with reads on get cycles and writes on put cycles.
module oam_dma_arbiter
    import nese_bus_pkg::*;
#(
    parameter logic [15:0] TRIG_ADDR = DEF_TRIG_ADDR,
    parameter logic [15:0] OAM_ADDR  = DEF_OAM_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_ab,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_rw,
    output logic        cpu_rdy,
    output logic [15:0] bus_ab,
    output logic [7:0]  bus_dout,
    output logic        bus_rw,
    input  logic [7:0]  bus_din,
    output logic        dma_active
);

    dma_state_t r_state;
    dma_state_t w_state_nxt;
    logic [7:0] r_idx;
    logic [7:0] r_page;
    logic [7:0] r_data;
    logic       r_put;
    logic       w_trig;

    assign w_trig = (cpu_rw != RW_READ) && (cpu_ab == TRIG_ADDR);

    // Bus mux and next-state share one decode; CPU pass-through is the default.
    always_comb begin
        w_state_nxt = r_state;
        bus_ab      = cpu_ab;
        bus_dout    = cpu_dout;
        bus_rw      = cpu_rw;
        case (r_state)
            IDLE: begin
                if (w_trig)
                    w_state_nxt = HALT;
            end
            HALT: begin
                // The CPU only stops on a read; a pending write must finish first.
                if (cpu_rw == RW_READ)
                    w_state_nxt = r_put ? READ : ALIGN;
            end
            ALIGN: begin
                bus_rw      = RW_READ;
                w_state_nxt = READ;
            end
            READ: begin
                bus_ab      = {r_page, r_idx};
                bus_rw      = RW_READ;
                w_state_nxt = WRITE;
            end
            WRITE: begin
                bus_ab      = OAM_ADDR;
                bus_rw      = ~RW_READ;
                bus_dout    = r_data;
                w_state_nxt = (r_idx == 8'hFF) ? IDLE : READ;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign cpu_rdy    = (r_state == IDLE);
    assign dma_active = ~cpu_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= 8'h00;
            r_page  <= 8'h00;
            r_data  <= 8'h00;
            r_put   <= 1'b0;
        end else begin
            r_put   <= ~r_put;
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_trig) begin
                        r_page <= cpu_dout;
                        r_idx  <= 8'h00;
                    end
                end
                READ:    r_data <= bus_din;
                WRITE:   r_idx  <= r_idx + 8'h01;
                default: ;
            endcase
        end
    end

endmodule
